// File: rtl/tx_fifo_arbiter.sv
// ============================================================================
// tx_fifo_arbiter: round-robin write-side scheduler feeding the TX FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_fifo_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,       // synchronous, active-low
    input  logic [DATA_WIDTH-1:0]   rf_data_i,
    input  logic                    rf_valid_i,
    input  logic [2*DATA_WIDTH-1:0] alu_data_i,
    input  logic                    alu_valid_i,
    input  logic                    fifo_full_i,
    input  logic                    clr_err_i,
    output logic [DATA_WIDTH-1:0]   fifo_wdata_o,
    output logic                    fifo_winc_o,
    output logic                    rf_pending_o,
    output logic                    alu_pending_o,
    output logic                    busy_o,
    output logic                    ovf_err_o
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_SEND_RF     = 2'd1;
    localparam logic [1:0] S_SEND_ALU_LO = 2'd2;
    localparam logic [1:0] S_SEND_ALU_HI = 2'd3;

    localparam logic GRANT_RF  = 1'b0;
    localparam logic GRANT_ALU = 1'b1;

    logic [1:0]              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   rf_buf_q, rf_buf_d;
    logic [2*DATA_WIDTH-1:0] alu_buf_q, alu_buf_d;
    logic                    rf_pend_q, rf_pend_d;
    logic                    alu_pend_q, alu_pend_d;
    logic                    ovf_q, ovf_d;

    logic wr;
    logic rf_release, alu_release;
    logic rf_drop, alu_drop;

    assign wr          = (state_q != S_IDLE) && !fifo_full_i;
    assign rf_release  = wr && (state_q == S_SEND_RF);
    assign alu_release = wr && (state_q == S_SEND_ALU_HI);
    assign rf_drop     = rf_valid_i && rf_pend_q && !rf_release;
    assign alu_drop    = alu_valid_i && alu_pend_q && !alu_release;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_ALU;
            rf_buf_q     <= '0;
            alu_buf_q    <= '0;
            rf_pend_q    <= 1'b0;
            alu_pend_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rf_buf_q     <= rf_buf_d;
            alu_buf_q    <= alu_buf_d;
            rf_pend_q    <= rf_pend_d;
            alu_pend_q   <= alu_pend_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (rf_pend_q && (!alu_pend_q || last_grant_q == GRANT_ALU)) begin
                    state_d      = S_SEND_RF;
                    last_grant_d = GRANT_RF;
                end else if (alu_pend_q) begin
                    state_d      = S_SEND_ALU_LO;
                    last_grant_d = GRANT_ALU;
                end
            end
            S_SEND_RF:     if (wr) state_d = S_IDLE;
            S_SEND_ALU_LO: if (wr) state_d = S_SEND_ALU_HI;
            S_SEND_ALU_HI: if (wr) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // A strobe on the release edge reloads the buffer and keeps it pending.
    always_comb begin
        rf_buf_d   = rf_buf_q;
        rf_pend_d  = rf_pend_q;
        alu_buf_d  = alu_buf_q;
        alu_pend_d = alu_pend_q;
        if (rf_valid_i && !rf_drop) begin
            rf_buf_d  = rf_data_i;
            rf_pend_d = 1'b1;
        end else if (rf_release) begin
            rf_pend_d = 1'b0;
        end
        if (alu_valid_i && !alu_drop) begin
            alu_buf_d  = alu_data_i;
            alu_pend_d = 1'b1;
        end else if (alu_release) begin
            alu_pend_d = 1'b0;
        end
        if (rf_drop || alu_drop) begin
            ovf_d = 1'b1;
        end else if (clr_err_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        fifo_winc_o  = wr;
        fifo_wdata_o = '0;
        case (state_q)
            S_SEND_RF:     fifo_wdata_o = rf_buf_q;
            S_SEND_ALU_LO: fifo_wdata_o = alu_buf_q[DATA_WIDTH-1:0];
            S_SEND_ALU_HI: fifo_wdata_o = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
            default:       fifo_wdata_o = '0;
        endcase
    end

    assign rf_pending_o  = rf_pend_q;
    assign alu_pending_o = alu_pend_q;
    assign busy_o        = (state_q != S_IDLE);
    assign ovf_err_o     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_fifo_arbiter.sv
// ============================================================================
// tb_tx_fifo_arbiter: scoreboard bench for tx_fifo_arbiter with a byte-queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tx_fifo_arbiter;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] rf_data;
    logic          rf_valid;
    logic [2*DW-1:0] alu_data;
    logic          alu_valid;
    logic          fifo_full;
    logic          clr_err;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_winc;
    logic          rf_pending;
    logic          alu_pending;
    logic          busy;
    logic          ovf_err;

    tx_fifo_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .rf_data_i     (rf_data),
        .rf_valid_i    (rf_valid),
        .alu_data_i    (alu_data),
        .alu_valid_i   (alu_valid),
        .fifo_full_i   (fifo_full),
        .clr_err_i     (clr_err),
        .fifo_wdata_o  (fifo_wdata),
        .fifo_winc_o   (fifo_winc),
        .rf_pending_o  (rf_pending),
        .alu_pending_o (alu_pending),
        .busy_o        (busy),
        .ovf_err_o     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          winc;
        logic [DW-1:0] data;
        logic          busy;
        logic          rfp;
        logic          alup;
        logic          ovf;
    } stat_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [DW-1:0] d;
    } wr_t;

    stat_t stat_q[$];
    wr_t   wr_q[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: a transfer in flight is just a list of bytes still to write.
    logic            m_rf_pend, m_alu_pend, m_last_alu, m_ovf, m_cur_alu;
    logic [DW-1:0]   m_rf_buf;
    logic [2*DW-1:0] m_alu_buf;
    logic [DW-1:0]   m_cur[$];

    task automatic model_reset();
        m_rf_pend  = 1'b0;
        m_alu_pend = 1'b0;
        m_last_alu = 1'b1;
        m_ovf      = 1'b0;
        m_cur_alu  = 1'b0;
        m_rf_buf   = '0;
        m_alu_buf  = '0;
        m_cur.delete();
    endtask

    initial model_reset();

    always @(negedge clk) begin : model
        stat_t         s;
        logic          idle, rf_rel, alu_rel, rf_drop, alu_drop;
        logic [DW-1:0] head;
        wr_t           w;
        idle   = (m_cur.size() == 0);
        head   = idle ? '0 : m_cur[0];
        s.winc = !idle && !fifo_full;
        s.data = head;
        s.busy = !idle;
        s.rfp  = m_rf_pend;
        s.alup = m_alu_pend;
        s.ovf  = m_ovf;
        stat_q.push_back(s);
        if (s.winc) begin
            w.cyc = cyc;
            w.d   = head;
            wr_q.push_back(w);
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            rf_rel  = 1'b0;
            alu_rel = 1'b0;
            if (s.winc) begin
                void'(m_cur.pop_front());
                if (m_cur.size() == 0) begin
                    if (m_cur_alu) alu_rel = 1'b1;
                    else           rf_rel  = 1'b1;
                end
            end
            if (idle) begin
                if (m_rf_pend && (!m_alu_pend || m_last_alu)) begin
                    m_cur.push_back(m_rf_buf);
                    m_cur_alu  = 1'b0;
                    m_last_alu = 1'b0;
                end else if (m_alu_pend) begin
                    m_cur.push_back(m_alu_buf[DW-1:0]);
                    m_cur.push_back(m_alu_buf[2*DW-1:DW]);
                    m_cur_alu  = 1'b1;
                    m_last_alu = 1'b1;
                end
            end
            rf_drop  = rf_valid && m_rf_pend && !rf_rel;
            alu_drop = alu_valid && m_alu_pend && !alu_rel;
            if (rf_valid && !rf_drop) begin
                m_rf_buf  = rf_data;
                m_rf_pend = 1'b1;
            end else if (rf_rel) begin
                m_rf_pend = 1'b0;
            end
            if (alu_valid && !alu_drop) begin
                m_alu_buf  = alu_data;
                m_alu_pend = 1'b1;
            end else if (alu_rel) begin
                m_alu_pend = 1'b0;
            end
            if (rf_drop || alu_drop) m_ovf = 1'b1;
            else if (clr_err)        m_ovf = 1'b0;
        end
    end

    always begin : monitor
        stat_t s;
        stat_t a;
        wr_t   w;
        @(negedge clk);
        #1;
        a.winc = fifo_winc;
        a.data = fifo_wdata;
        a.busy = busy;
        a.rfp  = rf_pending;
        a.alup = alu_pending;
        a.ovf  = ovf_err;
        if (stat_q.size() == 0) begin
            check("status_queue_empty", 32'd0, 32'd1);
        end else begin
            s = stat_q.pop_front();
            check("status{winc,data,busy,rfp,alup,ovf}", 32'(a), 32'(s));
        end
        check("winc_while_full", 32'(fifo_winc & fifo_full), 32'd0);
        if (fifo_winc === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
            end else begin
                w = wr_q.pop_front();
                check("wr_data", 32'(fifo_wdata), 32'(w.d));
                check("wr_cycle", 32'(cyc), w.cyc);
            end
        end
    end

    task automatic step(input logic rfv, input logic [DW-1:0] rfd, input logic av,
                        input logic [2*DW-1:0] ad, input logic full, input logic clr,
                        input logic rstn);
        rf_valid  = rfv;
        rf_data   = rfd;
        alu_valid = av;
        alu_data  = ad;
        fifo_full = full;
        clr_err   = clr;
        rst_n     = rstn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic full);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, full, 1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // RF single byte, then ALU byte order
        step(1'b1, 8'hA5, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);
        step(1'b0, '0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b0);

        // Round-robin ties after reset
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);
        step(1'b1, 8'h44, 1'b1, 16'h5566, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);

        // Backpressure between ALU bytes, with an RF strobe during the stall
        step(1'b0, '0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        idle(6, 1'b0);

        // Overflow, clear, and drop coinciding with clear
        idle(1, 1'b1);
        step(1'b1, 8'h01, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        step(1'b1, 8'h02, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        idle(3, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0);
        step(1'b1, 8'h03, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        step(1'b1, 8'h04, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Reset right after the ALU low byte, then a tie
        step(1'b0, '0, 1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 8'h99, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), DW'($urandom),
                 ($urandom_range(0, 3) == 0), (2*DW)'($urandom),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 199) != 0));
        end

        idle(8, 1'b0);
        @(negedge clk);
        #2;
        check("leftover_expected_writes", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
